// File: rtl/video_sync_gen.sv
// rtl/video_sync_gen.sv - raster timing generator: pixel/line counters with registered sync, active and frame-start flags
module video_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Enable,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic        o_Active,
    output logic [10:0] o_Col_Count,
    output logic [10:0] o_Row_Count,
    output logic        o_Frame_Start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last legal counter values; totals never exceed 2048 so these fit in 11 bits.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Region boundaries kept at 12 bits so a boundary equal to 2048 still compares correctly.
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // HOLD: counters parked at the origin; RUN: counters advance every cycle.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        active_q, active_d;
    logic        frame_start_q, frame_start_d;

    logic [11:0] col_ext;
    logic [11:0] row_ext;

    // Next position plus flags decoded from that same next position, so every
    // registered output describes the position shown on the counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;

        if (!i_Enable) begin
            state_d = ST_HOLD;
            col_d   = 11'd0;
            row_d   = 11'd0;
        end else if (state_q == ST_HOLD) begin
            // Restart always begins a fresh frame at the origin.
            state_d = ST_RUN;
            col_d   = 11'd0;
            row_d   = 11'd0;
        end else if (col_q == H_LAST) begin
            col_d = 11'd0;
            row_d = (row_q == V_LAST) ? 11'd0 : row_q + 11'd1;
        end else begin
            col_d = col_q + 11'd1;
        end

        col_ext = {1'b0, col_d};
        row_ext = {1'b0, row_d};

        active_d      = i_Enable && (col_ext < H_ACT_END) && (row_ext < V_ACT_END);
        frame_start_d = i_Enable && (col_d == 11'd0) && (row_d == 11'd0);
        hsync_d       = (i_Enable && (col_ext >= H_SYNC_BEG) && (col_ext < H_SYNC_END))
                        ? SYNC_ON : SYNC_OFF;
        vsync_d       = (i_Enable && (row_ext >= V_SYNC_BEG) && (row_ext < V_SYNC_END))
                        ? SYNC_ON : SYNC_OFF;
    end

    // State, counters and output flags; reset parks everything with syncs deasserted.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= ST_HOLD;
            col_q         <= 11'd0;
            row_q         <= 11'd0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Active      = active_q;
    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Start = frame_start_q;

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch, in lines.
REQ-009 Parameter SYNC_POL, default 1; 1 = syncs active-high, 0 = syncs active-low.
REQ-010 i_Clk  input  1  pixel clock; the block's only clock.
REQ-011 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-012 i_Enable  input  1  run/hold control for the timing counters.
REQ-013 o_HSync  output  1  horizontal sync, at polarity SYNC_POL.
REQ-014 o_VSync  output  1  vertical sync, at polarity SYNC_POL.
REQ-015 o_Active  output  1  high while the current pixel is visible.
REQ-016 o_Col_Count  output  11  horizontal position, 0..H_TOTAL-1.
REQ-017 o_Row_Count  output  11  vertical position, 0..V_TOTAL-1.
REQ-018 o_Frame_Start  output  1  one-cycle pulse at position (0,0).

Function
REQ-019 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; each SHALL be at most 2048.
REQ-020 All outputs SHALL be registered on i_Clk; there SHALL be no combinational path from any input to any output.
REQ-021 Position alignment: in every cycle, o_HSync, o_VSync, o_Active and o_Frame_Start SHALL describe the position currently shown on o_Col_Count/o_Row_Count; skew between them SHALL be 0 cycles.
REQ-022 While i_Enable=1, o_Col_Count SHALL increment by 1 per cycle and wrap from H_TOTAL-1 to 0.
REQ-023 o_Row_Count SHALL increment only in the cycle where o_Col_Count wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-024 o_Active SHALL be 1 iff o_Col_Count < H_ACTIVE and o_Row_Count < V_ACTIVE.
REQ-025 Horizontal sync SHALL be asserted iff H_ACTIVE+H_FP <= o_Col_Count < H_ACTIVE+H_FP+H_SYNC.
REQ-026 Vertical sync SHALL be asserted iff V_ACTIVE+V_FP <= o_Row_Count < V_ACTIVE+V_FP+V_SYNC, for whole lines.
   - Vertical sync changes state only at the line boundary, coincident with o_Col_Count = 0.
REQ-027 Asserted sync level SHALL be SYNC_POL and deasserted level SHALL be ~SYNC_POL.
REQ-028 o_Frame_Start SHALL be 1 for exactly one cycle per frame, when o_Col_Count = 0 and o_Row_Count = 0.
REQ-029 Hold behaviour: while i_Enable=0, the block SHALL hold both counters at 0, drive o_Active=0 and o_Frame_Start=0, and drive both syncs deasserted.
REQ-030 Enable restart: on the first clock edge with i_Enable=1 after a hold, outputs SHALL show position (0,0).
   - o_Frame_Start=1 and o_Active=1 in that cycle.
   - The frame always restarts from the origin; no mid-frame resume.
REQ-031 Enable drop: deassertion of i_Enable mid-frame SHALL take effect on the next clock edge; the partial frame is abandoned.
REQ-032 Counter arithmetic SHALL be unsigned 11-bit; counters SHALL never reach H_TOTAL or V_TOTAL.

Reset
REQ-033 Assertion of i_Rst_n=0 SHALL immediately, without waiting for a clock edge, drive:
   - o_Col_Count = 0 and o_Row_Count = 0;
   - o_Active = 0 and o_Frame_Start = 0;
   - o_HSync and o_VSync to ~SYNC_POL.
REQ-034 After i_Rst_n deasserts, the block SHALL behave exactly as after a hold: the first edge with i_Enable=1 yields position (0,0) with o_Frame_Start=1.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; no partial sync pulse SHALL remain asserted.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), SYNC_POL=1.
REQ-036 Reset then i_Enable=1 -> first active cycle shows Col=0, Row=0, Frame_Start=1, Active=1; Col reaches 13, then 0 with Row=1.
REQ-037 Free run for one full line -> HSync=1 exactly at Col 10..11; Active=1 exactly at Col 0..7 on Rows 0..3.
REQ-038 Free run for one full frame -> VSync=1 exactly for Rows 5 (all 14 cycles); Frame_Start period = 98 cycles; Active count per frame = 32.
REQ-039 Drop i_Enable at Col=5, Row=2 for 3 cycles, then raise -> during hold Col=Row=0, syncs low, Active=0; on resume Frame_Start=1 at (0,0).
REQ-040 Assert i_Rst_n=0 asynchronously between edges while HSync=1 -> HSync falls and counters clear before the next edge.
REQ-041 Rerun REQ-037 with SYNC_POL=0 -> HSync idles at 1 and is 0 exactly at Col 10..11.
